// File: rtl/mem_stage_p.sv
// Memory pipeline stage: issues data-memory requests, waits for ack with a
// bounded timeout, and registers the M->W pipeline boundary.
// Optional build macro MISALIGN_TRAP_EN: trap misaligned accesses instead of rounding them down.
module mem_stage_p #(
   parameter int DATA_W  = 32,
   parameter int REG_W   = 5,
   parameter int TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                RegWriteM,
   input  logic                MemtoRegM,
   input  logic                MemWriteM,
   input  logic                MemSignedM,
   input  logic [1:0]          MemSizeM,
   input  logic [REG_W-1:0]    WriteRegM,
   input  logic [DATA_W-1:0]   ALUOutM,
   input  logic [DATA_W-1:0]   WriteDataM,
   output logic                dm_req,
   output logic                dm_we,
   output logic [DATA_W-1:0]   dm_addr,
   output logic [DATA_W-1:0]   dm_wdata,
   output logic [DATA_W/8-1:0] dm_be,
   input  logic [DATA_W-1:0]   dm_rdata,
   input  logic                dm_ack,
   output logic                RegWriteW,
   output logic                MemtoRegW,
   output logic [REG_W-1:0]    WriteRegW,
   output logic [DATA_W-1:0]   ALUOutW,
   output logic [DATA_W-1:0]   ReadDataW,
   output logic                StallM,
   output logic                BusErr,
   output logic                MisalignW
);

   localparam int BE_W  = DATA_W / 8;
   localparam int OFF_W = $clog2(BE_W);
`ifdef MISALIGN_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   typedef enum logic {IDLE, WAIT} state_t;

   state_t state_q, state_d;
   logic [7:0] cnt_q, cnt_d;

   logic is_load, is_store, access, req_access;
   logic [1:0] size_eff;
   logic [3:0] size_bytes;
   logic [OFF_W-1:0] off_raw, size_mask, off;
   logic misaligned, mis_trap, timeout_hit, timed_out;

   // A cycle with both load and store set behaves as a store.
   assign is_store   = MemWriteM;
   assign is_load    = MemtoRegM & ~MemWriteM;
   assign access     = is_load | is_store;

   assign size_eff   = (DATA_W == 32 && MemSizeM == 2'b11) ? 2'b10 : MemSizeM;
   assign size_bytes = 4'd1 << size_eff;
   assign size_mask  = OFF_W'(size_bytes - 4'd1);
   assign off_raw    = ALUOutM[OFF_W-1:0];
   assign misaligned = |(off_raw & size_mask);
   assign off        = off_raw & ~size_mask;

   assign mis_trap    = TRAP_EN & access & misaligned;
   assign req_access  = access & ~mis_trap;
   assign timeout_hit = (state_q == WAIT) & req_access & (cnt_q == 8'(TIMEOUT - 1));
   assign timed_out   = timeout_hit & ~dm_ack;
   assign StallM      = rst_n & req_access & ~dm_ack & ~timeout_hit;

   // NOTE: every variable gets its default before the case so no latch is inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            cnt_d = 8'd0;
            if (req_access && !dm_ack) state_d = WAIT;
         end
         WAIT: begin
            if (!req_access || dm_ack || timeout_hit) begin
               state_d = IDLE;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 8'd0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Byte views of the store data and the lane-aligned read data.
   logic [7:0]        wd_bytes [BE_W];
   logic [7:0]        rs_bytes [BE_W];
   logic [DATA_W-1:0] wdata_rep, rd_shift, rd_mask, rd_ext;
   logic [2*BE_W-1:0] be_ones;
   logic              sign_bit;

   always_comb begin
      rd_shift  = dm_rdata >> {off, 3'b000};
      wdata_rep = '0;
      rd_mask   = '0;
      for (int i = 0; i < BE_W; i++) begin
         wd_bytes[i] = WriteDataM[8*i +: 8];
         rs_bytes[i] = rd_shift[8*i +: 8];
      end
      for (int i = 0; i < BE_W; i++) begin
         wdata_rep[8*i +: 8] = wd_bytes[OFF_W'(i) & size_mask];
         rd_mask[8*i +: 8]   = (i < int'(size_bytes)) ? 8'hFF : 8'h00;
      end
      sign_bit = rs_bytes[size_mask][7];
      rd_ext   = (rd_shift & rd_mask) | ((MemSignedM && sign_bit) ? ~rd_mask : '0);
      be_ones  = ((2*BE_W)'(1) << size_bytes) - (2*BE_W)'(1);
   end

   always_comb begin
      dm_req   = 1'b0;
      dm_we    = 1'b0;
      dm_addr  = '0;
      dm_wdata = '0;
      dm_be    = '0;
      if (rst_n && req_access) begin
         dm_req               = 1'b1;
         dm_we                = is_store;
         dm_addr              = ALUOutM;
         dm_addr[OFF_W-1:0]   = '0;
         if (is_store) begin
            dm_wdata = wdata_rep;
            dm_be    = BE_W'(be_ones << off);
         end else begin
            dm_be    = '1;
         end
      end
   end

   logic              reg_write_q, reg_write_d;
   logic              mem_to_reg_q, mem_to_reg_d;
   logic [REG_W-1:0]  write_reg_q;
   logic [DATA_W-1:0] alu_out_q, read_data_q, read_data_d;
   logic              bus_err_q, bus_err_d;
   logic              misalign_q, misalign_d;

   // A stall inserts a bubble; a timeout or trap retires without writeback.
   always_comb begin
      reg_write_d  = ~StallM & RegWriteM & ~timed_out & ~mis_trap;
      mem_to_reg_d = ~StallM & MemtoRegM;
      read_data_d  = (~StallM & req_access & is_load & dm_ack) ? rd_ext : '0;
      bus_err_d    = bus_err_q | timed_out;
      misalign_d   = mis_trap;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
         write_reg_q  <= '0;
         alu_out_q    <= '0;
         read_data_q  <= '0;
         bus_err_q    <= 1'b0;
         misalign_q   <= 1'b0;
      end else begin
         reg_write_q  <= reg_write_d;
         mem_to_reg_q <= mem_to_reg_d;
         write_reg_q  <= WriteRegM;
         alu_out_q    <= ALUOutM;
         read_data_q  <= read_data_d;
         bus_err_q    <= bus_err_d;
         misalign_q   <= misalign_d;
      end
   end

   assign RegWriteW = reg_write_q;
   assign MemtoRegW = mem_to_reg_q;
   assign WriteRegW = write_reg_q;
   assign ALUOutW   = alu_out_q;
   assign ReadDataW = read_data_q;
   assign BusErr    = bus_err_q;
   assign MisalignW = TRAP_EN ? misalign_q : 1'b0;

endmodule

// File: tb/tb_mem_stage_p.sv
// Directed bench for mem_stage_p (DATA_W=32, TIMEOUT=4); expectations are hand-computed.
module tb_mem_stage_p;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        RegWriteM, MemtoRegM, MemWriteM, MemSignedM;
   logic [1:0]  MemSizeM;
   logic [4:0]  WriteRegM;
   logic [31:0] ALUOutM, WriteDataM;
   logic        dm_req, dm_we;
   logic [31:0] dm_addr, dm_wdata;
   logic [3:0]  dm_be;
   logic [31:0] dm_rdata;
   logic        dm_ack;
   logic        RegWriteW, MemtoRegW;
   logic [4:0]  WriteRegW;
   logic [31:0] ALUOutW, ReadDataW;
   logic        StallM, BusErr, MisalignW;

   int checks = 0;
   int failures = 0;

   mem_stage_p #(.DATA_W(32), .REG_W(5), .TIMEOUT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
      .MemSignedM(MemSignedM), .MemSizeM(MemSizeM), .WriteRegM(WriteRegM),
      .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_be(dm_be), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
      .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .WriteRegW(WriteRegW),
      .ALUOutW(ALUOutW), .ReadDataW(ReadDataW),
      .StallM(StallM), .BusErr(BusErr), .MisalignW(MisalignW)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic rw, input logic mtr, input logic mw, input logic sgn,
                        input logic [1:0] sz, input logic [4:0] wr, input logic [31:0] alu,
                        input logic [31:0] wd, input logic [31:0] rd, input logic ack);
      RegWriteM = rw; MemtoRegM = mtr; MemWriteM = mw; MemSignedM = sgn;
      MemSizeM = sz; WriteRegM = wr; ALUOutM = alu; WriteDataM = wd;
      dm_rdata = rd; dm_ack = ack;
   endtask

   task automatic nop();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [73:0] w_all;
      rst_n = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 5'd3, 32'h100, 32'h0, 32'h0, 1'b0);
      #3;
      checks++; if (dm_req !== 1'b0) begin failures++; $display("FAIL reset_dm_req got=%0b exp=0", dm_req); end
      checks++; if (StallM !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", StallM); end
      next_cycle();
      w_all = {RegWriteW, MemtoRegW, WriteRegW, ALUOutW, ReadDataW, BusErr, MisalignW};
      checks++; if (w_all !== 74'h0) begin failures++; $display("FAIL reset_w_outputs got=%h exp=0", w_all); end
      nop();
      #2 rst_n = 1'b1;
      next_cycle();
   endtask

   task automatic test_word_load();
      drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 5'd5, 32'h100, 32'h0, 32'hDEADBEEF, 1'b1);
      #1;
      checks++; if (StallM !== 1'b0) begin failures++; $display("FAIL wload_stall got=%0b exp=0", StallM); end
      checks++; if ({dm_req, dm_we, dm_be} !== 6'b10_1111) begin failures++; $display("FAIL wload_req_we_be got=%b exp=101111", {dm_req, dm_we, dm_be}); end
      checks++; if (dm_addr !== 32'h100) begin failures++; $display("FAIL wload_addr got=%h exp=00000100", dm_addr); end
      next_cycle();
      checks++; if (ReadDataW !== 32'hDEADBEEF) begin failures++; $display("FAIL wload_rdata got=%h exp=deadbeef", ReadDataW); end
      checks++; if ({RegWriteW, MemtoRegW, WriteRegW} !== 7'b11_00101) begin failures++; $display("FAIL wload_ctrl got=%b exp=1100101", {RegWriteW, MemtoRegW, WriteRegW}); end
      checks++; if (ALUOutW !== 32'h100) begin failures++; $display("FAIL wload_aluout got=%h exp=00000100", ALUOutW); end
      nop();
   endtask

   task automatic test_byte_load();
      drive(1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 5'd6, 32'h103, 32'h0, 32'h80112233, 1'b1);
      #1;
      checks++; if (dm_addr !== 32'h100) begin failures++; $display("FAIL bload_addr got=%h exp=00000100", dm_addr); end
      next_cycle();
      checks++; if (ReadDataW !== 32'hFFFFFF80) begin failures++; $display("FAIL bload_signed got=%h exp=ffffff80", ReadDataW); end
      MemSignedM = 1'b0;
      next_cycle();
      checks++; if (ReadDataW !== 32'h00000080) begin failures++; $display("FAIL bload_unsigned got=%h exp=00000080", ReadDataW); end
      nop();
   endtask

   task automatic test_half_store();
      drive(1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 5'd7, 32'h202, 32'h0000ABCD, 32'h0, 1'b0);
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++; if ({StallM, dm_req, dm_we, dm_be} !== 7'b111_1100) begin failures++; $display("FAIL hstore_wait%0d_ctrl got=%b exp=1111100", c, {StallM, dm_req, dm_we, dm_be}); end
         checks++; if (dm_wdata !== 32'hABCDABCD || dm_addr !== 32'h200) begin failures++; $display("FAIL hstore_wait%0d_bus got=%h/%h exp=abcdabcd/00000200", c, dm_wdata, dm_addr); end
         next_cycle();
         checks++; if (RegWriteW !== 1'b0) begin failures++; $display("FAIL hstore_bubble%0d got=%0b exp=0", c, RegWriteW); end
      end
      dm_ack = 1'b1;
      #1;
      checks++; if ({StallM, dm_be} !== 5'b0_1100) begin failures++; $display("FAIL hstore_ack got=%b exp=01100", {StallM, dm_be}); end
      next_cycle();
      checks++; if ({RegWriteW, ReadDataW} !== {1'b1, 32'h0}) begin failures++; $display("FAIL hstore_retire got=%0b/%h exp=1/00000000", RegWriteW, ReadDataW); end
      nop();
   endtask

   task automatic test_back_to_back();
      drive(1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 5'd8, 32'h102, 32'h0, 32'h80011234, 1'b1);
      next_cycle();
      checks++; if (ReadDataW !== 32'hFFFF8001) begin failures++; $display("FAIL b2b_half_signed got=%h exp=ffff8001", ReadDataW); end
      drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 5'd9, 32'h104, 32'h0, 32'h89ABCDEF, 1'b1);
      #1;
      checks++; if ({StallM, dm_be} !== 5'b0_1111) begin failures++; $display("FAIL b2b_dword_be got=%b exp=01111", {StallM, dm_be}); end
      next_cycle();
      checks++; if ({WriteRegW, ReadDataW} !== {5'd9, 32'h89ABCDEF}) begin failures++; $display("FAIL b2b_dword got=%0d/%h exp=9/89abcdef", WriteRegW, ReadDataW); end
      nop();
   endtask

   task automatic test_misalign();
      drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 5'd10, 32'h102, 32'h0, 32'h11223344, 1'b1);
      #1;
`ifdef MISALIGN_TRAP_EN
      checks++; if ({dm_req, StallM} !== 2'b00) begin failures++; $display("FAIL mis_trap_req got=%b exp=00", {dm_req, StallM}); end
      next_cycle();
      checks++; if ({MisalignW, RegWriteW} !== 2'b10) begin failures++; $display("FAIL mis_trap_retire got=%b exp=10", {MisalignW, RegWriteW}); end
      nop();
      next_cycle();
      checks++; if (MisalignW !== 1'b0) begin failures++; $display("FAIL mis_trap_pulse got=%0b exp=0", MisalignW); end
`else
      checks++; if ({dm_req, StallM, dm_addr} !== {2'b10, 32'h100}) begin failures++; $display("FAIL mis_round_req got=%b/%h exp=10/00000100", {dm_req, StallM}, dm_addr); end
      next_cycle();
      checks++; if ({RegWriteW, MisalignW, ReadDataW} !== {2'b10, 32'h11223344}) begin failures++; $display("FAIL mis_round_load got=%b/%h exp=10/11223344", {RegWriteW, MisalignW}, ReadDataW); end
      nop();
`endif
   endtask

   task automatic test_timeout();
      drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 5'd11, 32'h300, 32'h0, 32'h55555555, 1'b0);
      for (int c = 0; c < 4; c++) begin
         #1;
         checks++; if (StallM !== 1'b1) begin failures++; $display("FAIL tmo_stall%0d got=%0b exp=1", c, StallM); end
         next_cycle();
         checks++; if (RegWriteW !== 1'b0) begin failures++; $display("FAIL tmo_bubble%0d got=%0b exp=0", c, RegWriteW); end
      end
      #1;
      checks++; if (StallM !== 1'b0) begin failures++; $display("FAIL tmo_release got=%0b exp=0", StallM); end
      next_cycle();
      checks++; if ({BusErr, RegWriteW, ReadDataW} !== {2'b10, 32'h0}) begin failures++; $display("FAIL tmo_retire got=%b/%h exp=10/00000000", {BusErr, RegWriteW}, ReadDataW); end
      nop();
      for (int c = 0; c < 3; c++) next_cycle();
      checks++; if (BusErr !== 1'b1) begin failures++; $display("FAIL tmo_sticky got=%0b exp=1", BusErr); end
   endtask

   task automatic test_reset_in_wait();
      logic [73:0] w_all;
      drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 5'd12, 32'h400, 32'h0, 32'h0, 1'b0);
      next_cycle();
      next_cycle();
      checks++; if ({StallM, ALUOutW} !== {1'b1, 32'h400}) begin failures++; $display("FAIL rstw_pre got=%0b/%h exp=1/00000400", StallM, ALUOutW); end
      rst_n = 1'b0;
      #1;
      w_all = {RegWriteW, MemtoRegW, WriteRegW, ALUOutW, ReadDataW, BusErr, MisalignW};
      checks++; if ({dm_req, StallM, dm_be, dm_addr} !== 38'h0) begin failures++; $display("FAIL rstw_bus got=%h exp=0", {dm_req, StallM, dm_be, dm_addr}); end
      checks++; if (w_all !== 74'h0) begin failures++; $display("FAIL rstw_w_outputs got=%h exp=0", w_all); end
      nop();
      next_cycle();
      rst_n = 1'b1;
      dm_ack = 1'b1;
      dm_rdata = 32'hCAFEF00D;
      for (int c = 0; c < 3; c++) begin
         next_cycle();
         w_all = {RegWriteW, MemtoRegW, WriteRegW, ALUOutW, ReadDataW, BusErr, MisalignW};
         checks++; if ({w_all, StallM, dm_req} !== 76'h0) begin failures++; $display("FAIL rstw_stray_ack%0d got=%h exp=0", c, {w_all, StallM, dm_req}); end
      end
      nop();
   endtask

   initial begin
      test_reset();
      test_word_load();
      test_byte_load();
      test_half_store();
      test_back_to_back();
      test_misalign();
      test_timeout();
      test_reset_in_wait();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
